// File: rtl/bus_cycle_pkg.sv
// Shared types and decode constants for the 68000 bus-cycle controller.
package bus_cycle_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, ACK, FAULT} state_t;

   typedef enum logic [1:0] {NONE, PROM, SRAM, IACK} region_t;

   localparam logic [3:0] REGION_PROM = 4'h0;
   localparam logic [3:0] REGION_SRAM = 4'h1;
   localparam logic [2:0] FC_IACK     = 3'b111;

endpackage

// File: rtl/bus_addr_decode.sv
// Classifies a registered CPU cycle into a memory region or an illegal access.
module bus_addr_decode
   import bus_cycle_pkg::*;
(
   input  logic [7:0] addr,
   input  logic [2:0] fc,
   input  logic       rw,
   output region_t    region,
   output logic       illegal
);

   // Only A23..A20 select a region; the low nibble is carried for completeness.
   logic unused_addr_low;
   assign unused_addr_low = ^addr[3:0];

   // Interrupt acknowledge wins over any address; PROM is read-only.
   always_comb begin
      region  = NONE;
      illegal = 1'b0;
      if (fc == FC_IACK) begin
         region = IACK;
      end else if (addr[7:4] == REGION_PROM && rw) begin
         region = PROM;
      end else if (addr[7:4] == REGION_SRAM) begin
         region = SRAM;
      end else begin
         illegal = 1'b1;
      end
   end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Synchronous 68000 bus-cycle controller: chip selects, strobes, wait states,
// DTACK/AVEC acknowledge and BERR on illegal accesses or watchdog timeout.
module bus_cycle_ctrl
   import bus_cycle_pkg::*;
#(
   parameter int unsigned PROM_WAIT    = 2,
   parameter int unsigned SRAM_WAIT    = 0,
   parameter int unsigned BERR_TIMEOUT = 64
) (
   input  logic       CPUCLK,
   input  logic       RESET,
   input  logic       AS,
   input  logic       UDS,
   input  logic       LDS,
   input  logic       RW,
   input  logic [2:0] FC,
   input  logic [7:0] A,
   output logic       PROMCS0,
   output logic       PROMCS1,
   output logic       SRAMCS0,
   output logic       SRAMCS1,
   output logic       OE,
   output logic       WEU,
   output logic       WEL,
   output logic       DTACK,
   output logic       AVEC,
   output logic       BERR
);

   localparam logic [3:0] PROM_WAIT_C = 4'(PROM_WAIT);
   localparam logic [3:0] SRAM_WAIT_C = 4'(SRAM_WAIT);
   localparam logic [7:0] WDOG_LAST   = 8'(BERR_TIMEOUT - 1);

   logic       as_r, uds_r, lds_r, rw_r;
   logic [2:0] fc_r;
   logic [7:0] a_r;

   state_t     state, state_next;
   logic [3:0] wcnt, wcnt_next;
   logic [7:0] wdog, wdog_next;
   region_t    cyc_region, cyc_region_next;
   logic       cyc_rw, cyc_rw_next;

   region_t    dec_region;
   logic       dec_illegal;

   logic [9:0] out_q, out_d;
   logic       strobe_active, sel_prom, sel_sram;

   bus_addr_decode u_decode (
      .addr    (a_r),
      .fc      (fc_r),
      .rw      (rw_r),
      .region  (dec_region),
      .illegal (dec_illegal)
   );

   always_ff @(posedge CPUCLK or negedge RESET) begin
      if (!RESET) begin
         as_r  <= 1'b1;
         uds_r <= 1'b1;
         lds_r <= 1'b1;
         rw_r  <= 1'b1;
         fc_r  <= 3'b000;
         a_r   <= 8'h00;
      end else begin
         as_r  <= AS;
         uds_r <= UDS;
         lds_r <= LDS;
         rw_r  <= RW;
         fc_r  <= FC;
         a_r   <= A;
      end
   end

   always_ff @(posedge CPUCLK or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         wcnt       <= 4'd0;
         wdog       <= 8'd0;
         cyc_region <= NONE;
         cyc_rw     <= 1'b1;
         out_q      <= '1;
      end else begin
         state      <= state_next;
         wcnt       <= wcnt_next;
         wdog       <= wdog_next;
         cyc_region <= cyc_region_next;
         cyc_rw     <= cyc_rw_next;
         out_q      <= out_d;
      end
   end

   // Abort beats watchdog, watchdog beats illegal decode, which beats wait states.
   always_comb begin
      state_next      = state;
      wcnt_next       = wcnt;
      wdog_next       = wdog;
      cyc_region_next = cyc_region;
      cyc_rw_next     = cyc_rw;
      case (state)
         IDLE: begin
            if (!as_r) begin
               state_next      = ACCESS;
               wdog_next       = 8'd0;
               cyc_rw_next     = rw_r;
               cyc_region_next = dec_illegal ? NONE : dec_region;
               case (dec_region)
                  PROM:    wcnt_next = PROM_WAIT_C;
                  SRAM:    wcnt_next = SRAM_WAIT_C;
                  default: wcnt_next = 4'd0;
               endcase
            end
         end
         ACCESS: begin
            wdog_next = (wdog == 8'hFF) ? wdog : wdog + 8'd1;
            if (as_r) begin
               state_next = IDLE;
            end else if (wdog == WDOG_LAST) begin
               state_next = FAULT;
            end else if (cyc_region == NONE) begin
               state_next = FAULT;
            end else if (wcnt == 4'd0) begin
               state_next = ACK;
            end else begin
               wcnt_next = wcnt - 4'd1;
            end
         end
         ACK, FAULT: begin
            if (as_r) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Strobes follow the live data strobes only while the cycle stays in progress.
   always_comb begin
      strobe_active = (state == ACCESS || state == ACK) &&
                      (state_next == ACCESS || state_next == ACK);
      sel_prom = strobe_active && (cyc_region == PROM);
      sel_sram = strobe_active && (cyc_region == SRAM);
      out_d    = '1;
      out_d[9] = ~(sel_prom & ~uds_r);
      out_d[8] = ~(sel_prom & ~lds_r);
      out_d[7] = ~(sel_sram & ~uds_r);
      out_d[6] = ~(sel_sram & ~lds_r);
      out_d[5] = ~((sel_prom | sel_sram) & cyc_rw);
      out_d[4] = ~(sel_sram & ~cyc_rw & ~uds_r);
      out_d[3] = ~(sel_sram & ~cyc_rw & ~lds_r);
      out_d[2] = ~((state_next == ACK) && (cyc_region != IACK));
      out_d[1] = ~((state_next == ACK) && (cyc_region == IACK));
      out_d[0] = ~(state_next == FAULT);
   end

   assign {PROMCS0, PROMCS1, SRAMCS0, SRAMCS1, OE, WEU, WEL, DTACK, AVEC, BERR} = out_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Table-driven bench for bus_cycle_ctrl; outputs are packed as
// {PROMCS0,PROMCS1,SRAMCS0,SRAMCS1,OE,WEU,WEL,DTACK,AVEC,BERR}.
module tb_bus_cycle_ctrl;

   localparam logic [9:0] ALL_HI       = 10'h3FF;
   localparam logic [9:0] PROM_RD      = 10'h0DF;
   localparam logic [9:0] PROM_RD_ACK  = 10'h0DB;
   localparam logic [9:0] SRAM_WRL_ACK = 10'h3B3;
   localparam logic [9:0] SRAM_RD      = 10'h31F;
   localparam logic [9:0] SRAM_RD_ACK  = 10'h31B;
   localparam logic [9:0] BERR_ONLY    = 10'h3FE;
   localparam logic [9:0] AVEC_ONLY    = 10'h3FD;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
   logic [2:0] fc = 3'b110;
   logic [7:0] a = 8'h00;
   logic [9:0] outs_a, outs_b;

   always #5 clk = ~clk;

   bus_cycle_ctrl dut_a (
      .CPUCLK(clk), .RESET(reset_n), .AS(as_n), .UDS(uds_n), .LDS(lds_n),
      .RW(rw), .FC(fc), .A(a),
      .PROMCS0(outs_a[9]), .PROMCS1(outs_a[8]), .SRAMCS0(outs_a[7]),
      .SRAMCS1(outs_a[6]), .OE(outs_a[5]), .WEU(outs_a[4]), .WEL(outs_a[3]),
      .DTACK(outs_a[2]), .AVEC(outs_a[1]), .BERR(outs_a[0])
   );

   bus_cycle_ctrl #(.PROM_WAIT(15), .SRAM_WAIT(3), .BERR_TIMEOUT(4)) dut_b (
      .CPUCLK(clk), .RESET(reset_n), .AS(as_n), .UDS(uds_n), .LDS(lds_n),
      .RW(rw), .FC(fc), .A(a),
      .PROMCS0(outs_b[9]), .PROMCS1(outs_b[8]), .SRAMCS0(outs_b[7]),
      .SRAMCS1(outs_b[6]), .OE(outs_b[5]), .WEU(outs_b[4]), .WEL(outs_b[3]),
      .DTACK(outs_b[2]), .AVEC(outs_b[1]), .BERR(outs_b[0])
   );

   typedef struct {
      logic       sel;
      int         grp;
      logic       as_v, uds_v, lds_v, rw_v;
      logic [2:0] fc_v;
      logic [7:0] a_v;
      logic [9:0] exp_v;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   passed = 0;

   task automatic checkOutput(input string name, input logic [9:0] got, input logic [9:0] want);
      checks++;
      if (got === want) passed++;
      else $display("[TB] FAIL %s: got %03h expected %03h", name, got, want);
   endtask

   task automatic applyStimulus(input logic as_v, uds_v, lds_v, rw_v,
                                input logic [2:0] fc_v, input logic [7:0] a_v);
      as_n  = as_v;
      uds_n = uds_v;
      lds_n = lds_v;
      rw    = rw_v;
      fc    = fc_v;
      a     = a_v;
   endtask

   task automatic addVec(input logic sel, input int grp, input logic as_v, uds_v, lds_v, rw_v,
                         input logic [2:0] fc_v, input logic [7:0] a_v, input logic [9:0] exp_v);
      vec_t t;
      t.sel = sel; t.grp = grp;
      t.as_v = as_v; t.uds_v = uds_v; t.lds_v = lds_v; t.rw_v = rw_v;
      t.fc_v = fc_v; t.a_v = a_v; t.exp_v = exp_v;
      vecs.push_back(t);
   endtask

   task automatic stepCheck(input string name, input logic sel, input logic [9:0] want);
      @(posedge clk);
      @(negedge clk);
      checkOutput(name, sel ? outs_b : outs_a, want);
   endtask

   initial begin
      #1 reset_n = 1'b0;
      #1;
      checkOutput("reset_a", outs_a, ALL_HI);
      checkOutput("reset_b", outs_b, ALL_HI);
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);

      // Group 1: PROM word read at 0x000004, DTACK four edges after AS.
      addVec(0, 1, 0, 0, 0, 1, 3'b110, 8'h00, ALL_HI);
      addVec(0, 1, 0, 0, 0, 1, 3'b110, 8'h00, ALL_HI);
      addVec(0, 1, 0, 0, 0, 1, 3'b110, 8'h00, PROM_RD);
      addVec(0, 1, 0, 0, 0, 1, 3'b110, 8'h00, PROM_RD);
      addVec(0, 1, 0, 0, 0, 1, 3'b110, 8'h00, PROM_RD_ACK);
      addVec(0, 1, 1, 1, 1, 1, 3'b110, 8'h00, PROM_RD_ACK);
      addVec(0, 1, 1, 1, 1, 1, 3'b110, 8'h00, ALL_HI);
      addVec(0, 1, 1, 1, 1, 1, 3'b110, 8'h00, ALL_HI);
      // Group 2: SRAM lower-byte write, LDS one clock late.
      addVec(0, 2, 0, 1, 1, 0, 3'b101, 8'h10, ALL_HI);
      addVec(0, 2, 0, 1, 0, 0, 3'b101, 8'h10, ALL_HI);
      addVec(0, 2, 0, 1, 0, 0, 3'b101, 8'h10, SRAM_WRL_ACK);
      addVec(0, 2, 1, 1, 1, 1, 3'b101, 8'h10, SRAM_WRL_ACK);
      addVec(0, 2, 1, 1, 1, 1, 3'b101, 8'h10, ALL_HI);
      addVec(0, 2, 1, 1, 1, 1, 3'b101, 8'h10, ALL_HI);
      // Group 3: PROM write is illegal.
      addVec(0, 3, 0, 0, 0, 0, 3'b101, 8'h00, ALL_HI);
      addVec(0, 3, 0, 0, 0, 0, 3'b101, 8'h00, ALL_HI);
      addVec(0, 3, 0, 0, 0, 0, 3'b101, 8'h00, BERR_ONLY);
      addVec(0, 3, 1, 1, 1, 1, 3'b101, 8'h00, BERR_ONLY);
      addVec(0, 3, 1, 1, 1, 1, 3'b101, 8'h00, ALL_HI);
      addVec(0, 3, 1, 1, 1, 1, 3'b101, 8'h00, ALL_HI);
      // Group 4: read of unmapped 0x500000.
      addVec(0, 4, 0, 0, 0, 1, 3'b101, 8'h50, ALL_HI);
      addVec(0, 4, 0, 0, 0, 1, 3'b101, 8'h50, ALL_HI);
      addVec(0, 4, 0, 0, 0, 1, 3'b101, 8'h50, BERR_ONLY);
      addVec(0, 4, 1, 1, 1, 1, 3'b101, 8'h50, BERR_ONLY);
      addVec(0, 4, 1, 1, 1, 1, 3'b101, 8'h50, ALL_HI);
      // Group 5: interrupt acknowledge answered by AVEC.
      addVec(0, 5, 0, 1, 0, 1, 3'b111, 8'hFF, ALL_HI);
      addVec(0, 5, 0, 1, 0, 1, 3'b111, 8'hFF, ALL_HI);
      addVec(0, 5, 0, 1, 0, 1, 3'b111, 8'hFF, AVEC_ONLY);
      addVec(0, 5, 1, 1, 1, 1, 3'b111, 8'hFF, AVEC_ONLY);
      addVec(0, 5, 1, 1, 1, 1, 3'b111, 8'hFF, ALL_HI);
      // Group 6: back-to-back SRAM reads with a single AS-high edge between.
      addVec(0, 6, 0, 0, 0, 1, 3'b101, 8'h10, ALL_HI);
      addVec(0, 6, 0, 0, 0, 1, 3'b101, 8'h10, ALL_HI);
      addVec(0, 6, 0, 0, 0, 1, 3'b101, 8'h10, SRAM_RD_ACK);
      addVec(0, 6, 1, 1, 1, 1, 3'b101, 8'h10, SRAM_RD_ACK);
      addVec(0, 6, 0, 0, 0, 1, 3'b101, 8'h10, ALL_HI);
      addVec(0, 6, 0, 0, 0, 1, 3'b101, 8'h10, ALL_HI);
      addVec(0, 6, 0, 0, 0, 1, 3'b101, 8'h10, SRAM_RD_ACK);
      addVec(0, 6, 1, 1, 1, 1, 3'b101, 8'h10, SRAM_RD_ACK);
      addVec(0, 6, 1, 1, 1, 1, 3'b101, 8'h10, ALL_HI);
      // Group 7: watchdog on the long-wait instance fires before DTACK.
      addVec(1, 7, 0, 0, 0, 1, 3'b110, 8'h00, ALL_HI);
      addVec(1, 7, 0, 0, 0, 1, 3'b110, 8'h00, ALL_HI);
      addVec(1, 7, 0, 0, 0, 1, 3'b110, 8'h00, PROM_RD);
      addVec(1, 7, 0, 0, 0, 1, 3'b110, 8'h00, PROM_RD);
      addVec(1, 7, 0, 0, 0, 1, 3'b110, 8'h00, PROM_RD);
      addVec(1, 7, 0, 0, 0, 1, 3'b110, 8'h00, BERR_ONLY);
      addVec(1, 7, 0, 0, 0, 1, 3'b110, 8'h00, BERR_ONLY);
      addVec(1, 7, 0, 0, 0, 1, 3'b110, 8'h00, BERR_ONLY);
      addVec(1, 7, 1, 1, 1, 1, 3'b110, 8'h00, BERR_ONLY);
      addVec(1, 7, 1, 1, 1, 1, 3'b110, 8'h00, ALL_HI);
      addVec(1, 7, 1, 1, 1, 1, 3'b110, 8'h00, ALL_HI);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].as_v, vecs[i].uds_v, vecs[i].lds_v, vecs[i].rw_v,
                       vecs[i].fc_v, vecs[i].a_v);
         stepCheck($sformatf("grp%0d_vec%0d", vecs[i].grp, i), vecs[i].sel, vecs[i].exp_v);
      end

      // Asynchronous reset in the middle of an SRAM access on the slow instance.
      applyStimulus(0, 0, 0, 1, 3'b101, 8'h10);
      stepCheck("rst_seq_e0", 1, ALL_HI);
      stepCheck("rst_seq_e1", 1, ALL_HI);
      stepCheck("rst_seq_e2_b", 1, SRAM_RD);
      checkOutput("rst_seq_e2_a", outs_a, SRAM_RD_ACK);
      reset_n = 1'b0;
      #1;
      checkOutput("rst_async_a", outs_a, ALL_HI);
      checkOutput("rst_async_b", outs_b, ALL_HI);
      applyStimulus(1, 1, 1, 1, 3'b101, 8'h10);
      @(negedge clk) reset_n = 1'b1;
      stepCheck("post_rst_idle", 0, ALL_HI);
      applyStimulus(0, 0, 0, 1, 3'b101, 8'h10);
      stepCheck("post_rst_e0", 0, ALL_HI);
      stepCheck("post_rst_e1", 0, ALL_HI);
      stepCheck("post_rst_e2", 0, SRAM_RD_ACK);
      applyStimulus(1, 1, 1, 1, 3'b101, 8'h10);
      stepCheck("post_rst_e3", 0, SRAM_RD_ACK);
      stepCheck("post_rst_e4", 0, ALL_HI);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
- Synchronous 68000 bus-cycle controller on CPUCLK; replaces the combinational DTACK term and the tied-off BERR/AVEC/OE.
- Decodes each CPU cycle and drives the PROM/SRAM byte-lane chip selects and the read/write strobes.
- Inserts per-region wait states before DTACK, answers interrupt-acknowledge cycles with AVEC, and raises BERR on unmapped or illegal accesses and on watchdog timeout.

Parameters:
- PROM_WAIT, 2, wait cycles between access start and DTACK for PROM (0..15).
- SRAM_WAIT, 0, wait cycles for SRAM (0..15).
- BERR_TIMEOUT, 64, CPUCLK cycles in ACCESS before forced BERR (2..255).

Ports:
- CPUCLK  in  1  CPU clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- AS  in  1  address strobe, active low.
- UDS  in  1  upper data strobe, active low.
- LDS  in  1  lower data strobe, active low.
- RW  in  1  1 = read, 0 = write.
- FC  in  3  function code.
- A  in  8  CPU address bits A23..A16.
- PROMCS0  out  1  PROM upper byte (D15..D8) select, active low.
- PROMCS1  out  1  PROM lower byte (D7..D0) select, active low.
- SRAMCS0  out  1  SRAM upper byte select, active low.
- SRAMCS1  out  1  SRAM lower byte select, active low.
- OE  out  1  memory output enable, active low.
- WEU  out  1  upper byte write enable, active low.
- WEL  out  1  lower byte write enable, active low.
- DTACK  out  1  data transfer acknowledge, active low.
- AVEC  out  1  autovector request, active low.
- BERR  out  1  bus error, active low.

Behaviour:
- Reset:
  - RESET low forces state IDLE and clears all counters and input registers (AS_r = 1).
  - Every output goes high immediately, asynchronously.
  - Reset asserted mid-cycle aborts the cycle with no DTACK, AVEC or BERR.
- Input stage:
  - AS, UDS, LDS, RW, FC and A are registered once (_r signals).
  - All decisions use the registered values.
  - All outputs are registered.
- Decode (of A_r[23:20], FC_r):
  - IACK: FC_r = 111.
  - PROM: A_r[23:20] = 0x0, read only.
  - SRAM: A_r[23:20] = 0x1.
  - ILLEGAL: PROM write, or any other address.
- States: IDLE, ACCESS, ACK, FAULT.
- IDLE:
  - On an edge with AS_r = 0, go to ACCESS.
  - Load wcnt with the region wait: PROM_WAIT, SRAM_WAIT, 0 for IACK.
  - Clear the watchdog counter wdog.
  - Latch the region and RW.
- ACCESS:
  - wdog increments every edge.
  - ILLEGAL region: go to FAULT at the first ACCESS edge; BERR asserts on that edge.
  - wcnt = 0: go to ACK. DTACK asserts (AVEC for IACK) on that edge.
  - wcnt > 0: decrement wcnt.
  - wdog = BERR_TIMEOUT-1 takes priority over both: go to FAULT.
  - AS_r = 1 (aborted cycle) takes priority over everything: go to IDLE with all outputs high, no acknowledge.
- Latency: AS low sampled at edge k gives DTACK low at edge k+2+WAIT, e.g. SRAM_WAIT = 0 gives k+2.
- ACK / FAULT:
  - DTACK/AVEC (ACK) or BERR (FAULT) is held low until AS_r = 1 is sampled.
  - On that edge go to IDLE and drive all outputs high.
  - DTACK and BERR are never low together.
- Lane strobes, recomputed every edge in ACCESS and ACK only:
  - PROMCS0 = ~(PROM & ~UDS_r); PROMCS1 = ~(PROM & ~LDS_r).
  - SRAMCS0 and SRAMCS1 follow the same rule for SRAM.
  - This tracks the late data strobes of 68000 write cycles.
- OE: low in ACCESS/ACK for reads of PROM or SRAM.
- WEU/WEL: low in ACCESS/ACK for SRAM writes with UDS_r/LDS_r low respectively.
- IACK cycles never assert any chip select, OE or WE.
- In FAULT, all chip selects, OE and WE are high.
- Back-to-back: a new cycle needs AS_r = 1 to be seen first, so AS high for at least one CPUCLK edge; no additional dead cycle.
- Widths: wcnt is 4 bits; wdog is 8 bits and saturates.

Decomposition:
- Package bus_cycle_pkg holds:
  - state enum (IDLE, ACCESS, ACK, FAULT);
  - region enum (NONE, PROM, SRAM, IACK);
  - constants REGION_PROM = 4'h0, REGION_SRAM = 4'h1, FC_IACK = 3'b111.
- One combinational sub-module, bus_addr_decode: (A_r, FC_r, RW_r) -> region, illegal.
- FSM, counters and output registers stay in bus_cycle_ctrl.

Test Plan:
- PROM word read at 0x000004, PROM_WAIT = 2, AS/UDS/LDS low at edge 0:
  - PROMCS0, PROMCS1 and OE low from edge 2; DTACK low at edge 4.
  - All outputs high one edge after AS is sampled high.
- SRAM byte write at 0x100001, LDS asserted one clock after AS, SRAM_WAIT = 0:
  - SRAMCS1 and WEL low only once LDS_r = 0; SRAMCS0 and WEU stay high.
  - DTACK low at edge 2.
- PROM write at 0x000000, and read at 0x500000:
  - BERR low at edge 2; no chip select, OE or WE ever low; DTACK stays high.
- IACK cycle, FC = 111, A = 0xFF:
  - AVEC low at edge 2; DTACK and all selects stay high.
- Watchdog, PROM_WAIT = 15, BERR_TIMEOUT = 4:
  - BERR low at edge 5, before DTACK.
  - DTACK never asserts; BERR released once AS_r = 1 is sampled.
- RESET pulled low in ACCESS with SRAMCS0 low:
  - All outputs high with no clock edge.
  - After release and AS high, the next cycle behaves normally.
